// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the round-robin shared-adder block.
package adder_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ID_W    = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Ceiling log2, used to validate that ID_W can encode every requester.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        int unsigned x;
        res = 0;
        x   = (val > 0) ? val - 1 : 0;
        while (x > 0) begin
            res = res + 1;
            x   = x >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N     = DEF_NUM_REQ,
    parameter int unsigned IDX_W = DEF_ID_W
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr_i) + off) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!valid_o && (i == cand) && req_i[i]) begin
                    valid_o    = 1'b1;
                    grant_o[i] = 1'b1;
                    idx_o      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin shared registered adder with valid/ready request and response ports.
// Define ADDER_RR_ARBITER_SAT_EN to clamp sums to the DATA_W range.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ID_W    = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W:0]           rsp_sum,
    output logic [ID_W-1:0]           rsp_id
);

    if ((NUM_REQ < 2) || (clog2(NUM_REQ) > ID_W)) begin : g_bad_cfg
        $error("adder_rr_arbiter: ID_W too narrow for NUM_REQ or NUM_REQ < 2");
    end

    state_e              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
    logic                rsp_valid_q;
    logic [DATA_W:0]     rsp_sum_q;
    logic [ID_W-1:0]     rsp_id_q;

    logic                slot_free;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                xfer;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic [DATA_W:0]     sum_raw;
    logic [DATA_W:0]     sum_d;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .valid_o (grant_any)
    );

    // Pass-through drain lets a new winner load while the old result leaves.
    assign slot_free = (state_q == ST_EMPTY) | (rsp_valid_q & rsp_ready);
    assign req_ready = (rst_n && slot_free && grant_any) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = a_sel | req_a[i*DATA_W +: DATA_W];
                b_sel = b_sel | req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sum_raw = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADDER_RR_ARBITER_SAT_EN
    assign sum_d = sum_raw[DATA_W] ? {1'b0, {DATA_W{1'b1}}} : sum_raw;
`else
    assign sum_d = sum_raw;
`endif

    assign rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else if (xfer) begin
            state_q     <= ST_FULL;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= sum_d;
            rsp_id_q    <= grant_idx;
        end else begin
            case (state_q)
                ST_FULL: begin
                    if (rsp_ready) begin
                        state_q     <= ST_EMPTY;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: driver + reference model push, negedge monitor pops.
module tb_adder_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [DW:0]   sum;
        logic [IW-1:0] id;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW:0]       rsp_sum;
    logic [IW-1:0]     rsp_id;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   model_ptr  = 0;
    bit   model_full = 0;

    adder_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the sum each requester should see, from plain integer arithmetic.
    function automatic logic [DW:0] ref_sum(input int unsigned a, input int unsigned b);
        int unsigned s;
        s = a + b;
`ifdef ADDER_RR_ARBITER_SAT_EN
        if (s >= (1 << DW)) s = (1 << DW) - 1;
`endif
        return (DW+1)'(s);
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] v,
                        input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                        input logic rdy);
        logic [N-1:0] exp_rdy;
        int g;
        bit slot;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(model_full));
        exp_rdy = '0;
        if (!rst) begin
            chk("req_ready_rst", 32'(req_ready), 32'(exp_rdy));
            model_full = 0;
            model_ptr  = 0;
            exp_q.delete();
        end else begin
            slot = !model_full || rdy;
            g = -1;
            if (slot) begin
                for (int k = 0; k < int'(N); k++) begin
                    if (g < 0 && v[(model_ptr + k) % N]) g = (model_ptr + k) % N;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
                e.sum = ref_sum(int'(a[g*DW +: DW]), int'(b[g*DW +: DW]));
                e.id  = IW'(g);
                exp_q.push_back(e);
                model_ptr  = (g + 1) % N;
                model_full = 1;
            end else if (rdy) begin
                model_full = 0;
            end
        end
    endtask

    // Monitor: compare the held result against the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d sum %0h expected no response", rsp_id, rsp_sum);
            end else begin
                chk("rsp_sum", 32'(rsp_sum), 32'(exp_q[0].sum));
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [N*DW-1:0] rand_ops();
        logic [N*DW-1:0] r;
        for (int i = 0; i < int'(N); i++) begin
            r[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? {DW{1'b1}} : DW'($urandom);
        end
        return r;
    endfunction

    initial begin
        logic [N*DW-1:0] ones;
        logic [N*DW-1:0] op_a;
        logic [N*DW-1:0] op_b;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        ones      = {(N*DW){1'b1}};

        // Reset held with every requester valid.
        repeat (3) step(1'b0, '1, rand_ops(), rand_ops(), 1'b1);
        step(1'b1, '1, rand_ops(), rand_ops(), 1'b1);
        step(1'b1, '0, '0, '0, 1'b1);

        // Single request from requester 2: 5 + 7.
        op_a = '0; op_b = '0;
        op_a[2*DW +: DW] = DW'(5);
        op_b[2*DW +: DW] = DW'(7);
        step(1'b1, 4'b0100, op_a, op_b, 1'b1);
        step(1'b1, '0, '0, '0, 1'b1);
        step(1'b1, '0, '0, '0, 1'b1);

        // Round robin, all valid, no backpressure.
        repeat (6) step(1'b1, '1, rand_ops(), rand_ops(), 1'b1);

        // Backpressure for 5 cycles, then release.
        step(1'b1, '1, rand_ops(), rand_ops(), 1'b0);
        repeat (5) step(1'b1, '1, rand_ops(), rand_ops(), 1'b0);
        repeat (2) step(1'b1, '1, rand_ops(), rand_ops(), 1'b1);

        // Overflow operands on every lane.
        repeat (4) step(1'b1, '1, ones, ones, 1'b1);
        step(1'b1, '0, '0, '0, 1'b1);

        // Mid-operation reset while a result is held.
        step(1'b1, 4'b1000, rand_ops(), rand_ops(), 1'b0);
        step(1'b1, '0, '0, '0, 1'b0);
        step(1'b0, '1, rand_ops(), rand_ops(), 1'b0);
        step(1'b1, '0, '0, '0, 1'b0);
        step(1'b1, '1, rand_ops(), rand_ops(), 1'b1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) != 0), N'($urandom), rand_ops(), rand_ops(),
                 ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing is left outstanding.
        step(1'b1, '0, '0, '0, 1'b1);
        repeat (3) step(1'b1, '0, '0, '0, 1'b1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one registered adder among NUM_REQ requesters in the NPU datapath (e.g. partial-sum lanes) using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake.
- One winning pair per cycle is added into a single output register.
- The sum leaves with the winner's ID on a valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 16, operand width (unsigned).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand pair valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*DATA_W  operand A; requester i in bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand B; same packing as req_a.
- rsp_valid  output  1  sum register holds a result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_sum  output  DATA_W+1  unsigned sum including carry.
- rsp_id  output  ID_W  index of the requester that produced rsp_sum.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, rst_n, sampled on the rising edge of clk.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, state=EMPTY. req_ready=0 while rst_n=0.
- Reset mid-operation: any held result is discarded with no response. Requesters must re-present after reset.
- State machine:
  - EMPTY: output register free.
  - FULL: output register holds a result not yet taken.
- slot_free = (state==EMPTY) | (rsp_valid & rsp_ready). This gives a pass-through drain, so back-to-back throughput is 1 result per cycle.
- Grant: when slot_free, grant the first requester with req_valid=1, searching from rr_ptr upward with wrap-around mod NUM_REQ. req_ready is asserted combinationally for that requester only.
- No valid requester, or slot_free=0: all req_ready=0.
- Transfer happens when req_valid[g] & req_ready[g]. On the next edge:
  - rsp_sum <= zero-extended a + b.
  - rsp_id <= g.
  - rsp_valid <= 1, state <= FULL.
  - rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr changes only on a transfer.
- Latency: accepted operands appear on rsp_* exactly 1 cycle later.
- FULL with rsp_ready=1 and no new transfer: rsp_valid <= 0, state <= EMPTY. rsp_sum and rsp_id hold their last values.
- FULL with rsp_ready=0: rsp_sum, rsp_id and rsp_valid remain stable, and all req_ready=0.
- Simultaneous drain and transfer: the new result replaces the old one, rsp_valid stays 1, with no bubble.
- Arithmetic: unsigned, no overflow loss. Max result 2^(DATA_W+1)-2.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- req_valid may deassert without a handshake; no ordering is imposed on requesters.

Optional Feature:
- Macro: ADDER_RR_ARBITER_SAT_EN.
- Defined: if a+b >= 2^DATA_W, rsp_sum = {1'b0, {DATA_W{1'b1}}}, i.e. clamped to the DATA_W range with MSB forced to 0. Otherwise the result is identical to the unsaturated case.
- Undefined: the full DATA_W+1 sum is passed through.
- Port list and timing are identical in both builds.

Decomposition:
- Shared package adder_arb_pkg holds:
  - state enum (ST_EMPTY, ST_FULL);
  - DATA_W and NUM_REQ defaults;
  - function clog2 for ID_W checks.
- One natural sub-module: rr_arbiter. It is purely combinational, taking req vector and pointer and returning one-hot grant plus encoded index. It is reused by other shared NPU resources.
- The top holds rr_ptr, the state register, the adder and the output register.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> rsp_valid=0, req_ready=0. After release, the first grant goes to requester 0.
2. Single request: req 2 presents a=16'h0005, b=16'h0007 -> req_ready[2]=1 that cycle. Next cycle rsp_valid=1, rsp_sum=12, rsp_id=2.
3. Round-robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 with one result per cycle and no bubbles.
4. Backpressure: rsp_ready=0 for 5 cycles while FULL -> all req_ready=0 and rsp_sum/rsp_id stable. On rsp_ready=1, the same cycle grants the next requester and the following cycle shows the new result.
5. Overflow: a=b=16'hFFFF -> rsp_sum=17'h1FFFE. With ADDER_RR_ARBITER_SAT_EN, rsp_sum=17'h0FFFF.
6. Mid-operation reset: FULL with rsp_ready=0, assert rst_n=0 for 1 cycle -> rsp_valid=0 next cycle, rr_ptr=0, no stale response emitted.
